matmul_seq: RTL and testbench
=============================

MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameter N, default 4, matrix dimension (N x N operands, N>=2).
REQ-002 Parameter DP_LAT, default 3, cycles from dp_issue to matching dp_valid for the shared dot-product unit (DP_LAT>=1).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to run one full matrix multiply.
REQ-006 stall  input  1  suppresses new issues while high.
REQ-007 busy  output  1  run in progress.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 dp_issue  output  1  launch one dot product (row row_idx of A, column col_idx of B).
REQ-010 row_idx  output  $clog2(N)  A row select, valid with dp_issue.
REQ-011 col_idx  output  $clog2(N)  B column select, valid with dp_issue.
REQ-012 dp_valid  input  1  dot-product result valid, in issue order.
REQ-013 dp_result  input  27  dot-product result, valid with dp_valid.
REQ-014 wr_en  output  1  result write strobe.
REQ-015 wr_addr  output  $clog2(N*N)  result element index i*N+j.
REQ-016 wr_data  output  27  result element value.
REQ-017 err  output  1  sticky protocol error flag.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE: IDLE->ISSUE on start; ISSUE->DRAIN after issue N*N; DRAIN->DONE on write N*N; DONE->IDLE unconditionally.
REQ-019 start outside IDLE SHALL be ignored, with no effect on the current run.
REQ-020 In ISSUE with stall low, dp_issue SHALL be high for exactly one cycle per pair, row-major order (i outer, j inner), advancing one pair per cycle.
REQ-021 In ISSUE with stall high, dp_issue SHALL be low and row_idx/col_idx SHALL hold; stall SHALL NOT block result writes.
REQ-022 An outstanding counter SHALL +1 on issue, -1 on dp_valid, and stay unchanged when both occur in one cycle.
REQ-023 Each accepted dp_valid SHALL produce wr_en high the next cycle, with wr_data = registered dp_result and wr_addr = count of prior writes in this run (0..N*N-1).
REQ-024 dp_valid with outstanding==0 SHALL set err, produce no write, and leave the counters unchanged.
REQ-025 busy SHALL be high from the cycle after start is accepted through the done cycle inclusive.
REQ-026 done SHALL be high only in DONE, for one cycle.
REQ-027 With stall low throughout and start accepted at cycle 0: first dp_issue at cycle 1, last at cycle N*N, last wr_en at cycle N*N+DP_LAT+1, done at cycle N*N+DP_LAT+2.

Reset
REQ-028 Reset SHALL force IDLE and clear the issue index, write index and outstanding counter.
REQ-029 Reset SHALL drive busy, done, dp_issue, wr_en and err to 0, and row_idx, col_idx, wr_addr and wr_data to 0.
REQ-030 Reset mid-run SHALL abandon the run; dp_valid arriving after reset SHALL set err.

Configuration
REQ-031 With macro MATMUL_SEQ_PERF_EN defined, a 32-bit output cycle_count SHALL exist. It SHALL clear on accepted start, increment every cycle while busy including stalled cycles, hold after done, and reset to 0.
REQ-032 Without MATMUL_SEQ_PERF_EN, cycle_count and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 N=4, DP_LAT=3, start pulse, no stall, model returns result=issue ordinal -> 16 writes, addr 0..15 with data 0..15, done at cycle 21, busy cycles 1..21.
REQ-034 Same setup, stall high for cycles 3..6 -> no dp_issue in cycles 3..6, indices held, in-flight writes continue, done at cycle 25.
REQ-035 start re-pulsed at cycle 5 and again in the done cycle -> both ignored, exactly 16 writes, returns to IDLE.
REQ-036 Spurious dp_valid while idle -> err=1 sticky, no wr_en; a following normal run completes with err still 1 until reset.
REQ-037 Reset asserted at cycle 8, then a new start -> all outputs 0 immediately; new run writes addr 0..15 and completes normally.
REQ-038 With MATMUL_SEQ_PERF_EN, the REQ-034 run -> cycle_count=25 after done, and it holds until the next start.

Source files
------------

// File: rtl/matmul_seq_if.sv
// Handshake bundle between matmul_seq and its environment (start/stall, dot-product unit, result writes).
// Optional MATMUL_SEQ_PERF_EN adds the cycle_count performance output.
interface matmul_seq_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);
  localparam int AW = $clog2(N * N);

  logic          start;
  logic          stall;
  logic          busy;
  logic          done;
  logic          dp_issue;
  logic [IW-1:0] row_idx;
  logic [IW-1:0] col_idx;
  logic          dp_valid;
  logic [26:0]   dp_result;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [26:0]   wr_data;
  logic          err;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0]   cycle_count;

  modport slave (
    input  start, stall, dp_valid, dp_result,
    output busy, done, dp_issue, row_idx, col_idx, wr_en, wr_addr, wr_data, err, cycle_count
  );
  modport master (
    output start, stall, dp_valid, dp_result,
    input  busy, done, dp_issue, row_idx, col_idx, wr_en, wr_addr, wr_data, err, cycle_count
  );
`else
  modport slave (
    input  start, stall, dp_valid, dp_result,
    output busy, done, dp_issue, row_idx, col_idx, wr_en, wr_addr, wr_data, err
  );
  modport master (
    output start, stall, dp_valid, dp_result,
    input  busy, done, dp_issue, row_idx, col_idx, wr_en, wr_addr, wr_data, err
  );
`endif
endinterface

// File: rtl/matmul_seq.sv
// Sequencer for an N x N matrix multiply on a shared dot-product unit: issues row/column pairs,
// writes returned results in order. Optional MATMUL_SEQ_PERF_EN adds a busy-cycle counter.
module matmul_seq #(
  parameter int N      = 4,
  parameter int DP_LAT = 3
) (
  input  logic         clk,
  input  logic         reset,
  matmul_seq_if.slave  bus
);
  localparam int NN           = N * N;
  localparam int IW           = $clog2(N);
  localparam int AW           = $clog2(NN);
  localparam int MAX_INFLIGHT = (NN > DP_LAT + 1) ? NN : DP_LAT + 1;
  localparam int OW           = $clog2(MAX_INFLIGHT + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [OW-1:0] outst_q, outst_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [26:0]   wr_data_q, wr_data_d;
  logic          err_q, err_d;

  logic          issue_s;
  logic          accept_s;
  logic          last_pair_s;

  // Next-state, index, write and error logic.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    wcnt_d      = wcnt_q;
    outst_d     = outst_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_d       = err_q;
    issue_s     = (state_q == ISSUE) && !bus.stall;
    accept_s    = bus.dp_valid && (outst_q != {OW{1'b0}});
    last_pair_s = (row_q == LAST_IDX) && (col_q == LAST_IDX);

    // A result with nothing in flight is a protocol error and is dropped.
    if (accept_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wcnt_q;
      wr_data_d = bus.dp_result;
      wcnt_d    = wcnt_q + AW'(1);
    end else if (bus.dp_valid) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case ({issue_s, accept_s})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          row_d   = {IW{1'b0}};
          col_d   = {IW{1'b0}};
          wcnt_d  = {AW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (issue_s) begin
          if (col_q == LAST_IDX) begin
            col_d = {IW{1'b0}};
            if (row_q == LAST_IDX) begin
              row_d = {IW{1'b0}};
            end else begin
              row_d = row_q + IW'(1);
            end
          end else begin
            col_d = col_q + IW'(1);
          end
          if (last_pair_s) begin
            state_d = DRAIN;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= {IW{1'b0}};
      col_q     <= {IW{1'b0}};
      wcnt_q    <= {AW{1'b0}};
      outst_q   <= {OW{1'b0}};
      wr_en_q   <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_data_q <= 27'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wcnt_q    <= wcnt_d;
      outst_q   <= outst_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  // dp_issue follows stall within the same cycle so a stalled cycle never launches work.
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.dp_issue = issue_s;
  assign bus.row_idx  = row_q;
  assign bus.col_idx  = col_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.err      = err_q;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] cc_q, cc_d;

  // Busy-cycle counter: cleared on an accepted start, frozen once back in IDLE.
  always_comb begin
    cc_d = cc_q;
    if ((state_q == IDLE) && bus.start) begin
      cc_d = 32'd0;
    end else if (state_q != IDLE) begin
      cc_d = cc_q + 32'd1;
    end else begin
      cc_d = cc_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cc_q <= 32'd0;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign bus.cycle_count = cc_q;
`endif
endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: models the dot-product unit and checks every output every cycle.
module tb_matmul_seq;
  localparam int N      = 4;
  localparam int DP_LAT = 3;
  localparam int NN     = N * N;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matmul_seq_if #(.N(N)) bus();
  matmul_seq #(.N(N), .DP_LAT(DP_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural expectations for the current cycle.
  logic        m_active, m_done, m_wr, m_err;
  int          m_issued, m_written, m_outst, m_wr_addr;
  logic [26:0] m_wr_data;
  logic [31:0] m_cc;

  typedef struct {
    int          due;
    logic [26:0] data;
  } pend_t;
  pend_t pq[$];

  logic        rand_data = 1'b0;
  logic        spur      = 1'b0;
  logic        nxt_valid;
  logic [26:0] nxt_data;
  int          last_done_cyc, run_writes, last_wr_addr;
  logic [26:0] last_wr_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_done = 1'b0; m_wr = 1'b0; m_err = 1'b0;
    m_issued = 0; m_written = 0; m_outst = 0; m_wr_addr = 0;
    m_wr_data = 27'd0; m_cc = 32'd0;
    pq.delete();
  endtask

  // One clock: compare at negedge, advance the model, then drive the DP unit's response.
  task automatic cycle();
    logic  exp_issue, acc, nd, acc_start;
    pend_t p;
    @(negedge clk);
    if (reset) model_reset();
    exp_issue = m_active && !m_done && (m_issued < NN) && !bus.stall && !reset;
    chk("busy", bus.busy, m_active);
    chk("done", bus.done, m_done);
    chk("dp_issue", bus.dp_issue, exp_issue);
    if (exp_issue) begin
      chk("row_idx", bus.row_idx, m_issued / N);
      chk("col_idx", bus.col_idx, m_issued % N);
    end
    chk("wr_en", bus.wr_en, m_wr);
    if (m_wr) begin
      chk("wr_addr", bus.wr_addr, m_wr_addr);
      chk("wr_data", bus.wr_data, m_wr_data);
    end
    chk("err", bus.err, m_err);
`ifdef MATMUL_SEQ_PERF_EN
    chk("cycle_count", bus.cycle_count, m_cc);
`endif
    if (bus.done) last_done_cyc = cyc;
    if (bus.wr_en) begin
      run_writes++;
      last_wr_addr = bus.wr_addr;
      last_wr_data = bus.wr_data;
    end
    if (!reset) begin
      if (bus.dp_issue) begin
        p.due  = cyc + DP_LAT;
        p.data = rand_data ? 27'($urandom) : 27'(m_issued);
        pq.push_back(p);
      end
      acc = bus.dp_valid && (m_outst > 0);
      if (bus.dp_valid && (m_outst == 0)) m_err = 1'b1;
      nd = m_active && !m_done && m_wr && (m_wr_addr == NN - 1);
      m_wr = acc;
      if (acc) begin
        m_wr_addr = m_written;
        m_wr_data = bus.dp_result;
        m_written++;
      end
      m_outst  = m_outst + (exp_issue ? 1 : 0) - (acc ? 1 : 0);
      m_issued = m_issued + (exp_issue ? 1 : 0);
      acc_start = !m_active && bus.start;
      if (acc_start) m_cc = 32'd0;
      else if (m_active) m_cc = m_cc + 32'd1;
      if (m_done) m_active = 1'b0;
      else if (acc_start) begin
        m_active = 1'b1; m_issued = 0; m_written = 0;
      end
      m_done = nd;
    end
    nxt_valid = 1'b0;
    nxt_data  = 27'd0;
    if (pq.size() > 0 && pq[0].due == cyc + 1) begin
      nxt_valid = 1'b1;
      nxt_data  = pq[0].data;
      void'(pq.pop_front());
    end
    if (spur) begin
      nxt_valid = 1'b1;
      nxt_data  = 27'($urandom);
    end
    @(posedge clk);
    cyc++;
    #1;
    bus.dp_valid  = nxt_valid;
    bus.dp_result = nxt_data;
  endtask

  // Start a run at the current cycle and wait (bounded) for done; rel = done cycle relative to start.
  task automatic run(input int st_lo, input int st_hi, input int rep1, input int rep2,
                     input bit rnd_stall, output int rel);
    int t0, r;
    t0 = cyc;
    bus.start = 1'b1;
    run_writes = 0;
    last_done_cyc = -1;
    for (int k = 0; k < 200 && last_done_cyc < 0; k++) begin
      cycle();
      r = cyc - t0;
      bus.start = (r == rep1) || (r == rep2);
      bus.stall = rnd_stall ? ($urandom_range(0, 3) == 0) : (r >= st_lo && r <= st_hi);
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    rel = -1;
    checks++;
    if (last_done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout: got no done within 200 cycles, required done");
    end else begin
      rel = last_done_cyc - t0;
    end
  endtask

  initial begin
    int rel;
    bus.start = 1'b0; bus.stall = 1'b0; bus.dp_valid = 1'b0; bus.dp_result = 27'd0;
    reset = 1'b1;
    model_reset();
    repeat (3) cycle();
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_err", bus.err, 0);
    reset = 1'b0;
    repeat (2) cycle();

    // Plain run with ordinal results.
    run(100, -1, -1, -1, 1'b0, rel);
    chk("A_done_cycle", rel, 21);
    chk("A_writes", run_writes, 16);
    chk("A_last_addr", last_wr_addr, 15);
    chk("A_last_data", last_wr_data, 15);
    repeat (2) cycle();
    chk("A_idle_busy", bus.busy, 0);

    // Stall window 3..6.
    run(3, 6, -1, -1, 1'b0, rel);
    chk("B_done_cycle", rel, 25);
    chk("B_writes", run_writes, 16);
`ifdef MATMUL_SEQ_PERF_EN
    chk("B_cycle_count", bus.cycle_count, 25);
    repeat (5) cycle();
    chk("B_cycle_count_hold", bus.cycle_count, 25);
`endif
    repeat (2) cycle();

    // start re-pulsed mid-run and in the done cycle.
    run(100, -1, 5, 21, 1'b0, rel);
    chk("C_done_cycle", rel, 21);
    repeat (3) cycle();
    chk("C_writes", run_writes, 16);
    chk("C_idle_busy", bus.busy, 0);

    // Spurious result while idle, then a normal run.
    spur = 1'b1;
    cycle();
    spur = 1'b0;
    cycle();
    chk("D_err_set", bus.err, 1);
    chk("D_no_write", bus.wr_en, 0);
    run(100, -1, -1, -1, 1'b0, rel);
    chk("D_done_cycle", rel, 21);
    chk("D_err_sticky", bus.err, 1);
    reset = 1'b1;
    cycle();
    chk("D_err_cleared", bus.err, 0);
    reset = 1'b0;
    cycle();

    // Reset at cycle 8 of a run, then a fresh run.
    rand_data = 1'b1;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (7) cycle();
    reset = 1'b1;
    #1;
    chk("E_busy", bus.busy, 0);
    chk("E_dp_issue", bus.dp_issue, 0);
    chk("E_wr_en", bus.wr_en, 0);
    chk("E_wr_data", bus.wr_data, 0);
    chk("E_row_col", {bus.row_idx, bus.col_idx}, 0);
    cycle();
    reset = 1'b0;
    cycle();
    run(100, -1, -1, -1, 1'b0, rel);
    chk("E_done_cycle", rel, 21);
    chk("E_writes", run_writes, 16);
    chk("E_last_addr", last_wr_addr, 15);

    // Randomised stalls, data and stray start pulses.
    for (int i = 0; i < 6; i++) begin
      run(100, -1, $urandom_range(2, 30), $urandom_range(2, 30), 1'b1, rel);
      chk("R_writes", run_writes, 16);
      chk("R_done_late_enough", (rel >= 21) ? 1 : 0, 1);
      repeat ($urandom_range(1, 4)) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
